// File: rtl/mem_pkg.sv
// Shared request/response types for the L1-cache to main-memory ports.
package mem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              Valid;
    logic              Write;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] Wdata;
  } mem_input_t;

  typedef struct packed {
    logic [DATA_W-1:0] Rdata;
    logic              Ready;
  } mem_output_t;
endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing main memory between the icache (port 0) and the
// dcache (port 1); one transaction in flight, all outputs registered.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter bit RR_EN      = 1'b1,
  parameter bit FIXED_PRIO = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  mem_input_t  req0_i,
  output mem_output_t rsp0_o,
  input  mem_input_t  req1_i,
  output mem_output_t rsp1_o,
  output mem_input_t  mem_o,
  input  mem_output_t mem_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  mem_input_t        mem_r, mem_s;
  mem_output_t       rsp0_r, rsp0_s;
  mem_output_t       rsp1_r, rsp1_s;
  logic [1:0]        grant_r, grant_s;
  logic              last_r, last_s;
  logic              win_s;
  logic [DATA_W-1:0] rdata_s;

  // Winner selection; last_r remembers the port that won the previous grant
  always_comb begin
    win_s = 1'b0;
    if (req0_i.Valid && req1_i.Valid) begin
      if (RR_EN) begin
        win_s = ~last_r;
      end else begin
        win_s = FIXED_PRIO;
      end
    end else if (req1_i.Valid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Writes return zero data to the requester regardless of what mainmem drives
  assign rdata_s = mem_r.Write ? {DATA_W{1'b0}} : mem_i.Rdata;

  // Next-state and next-output logic
  always_comb begin
    state_s      = state_r;
    mem_s        = mem_r;
    mem_s.Valid  = 1'b0;
    rsp0_s       = rsp0_r;
    rsp0_s.Ready = 1'b0;
    rsp1_s       = rsp1_r;
    rsp1_s.Ready = 1'b0;
    grant_s      = grant_r;
    last_s       = last_r;
    case (state_r)
      ST_IDLE: begin
        if (req0_i.Valid || req1_i.Valid) begin
          // Fields latched here are what mainmem sees, whatever the requester does next
          mem_s       = win_s ? req1_i : req0_i;
          mem_s.Valid = 1'b1;
          grant_s     = win_s ? 2'b10 : 2'b01;
          last_s      = win_s;
          state_s     = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_i.Ready) begin
          if (grant_r[1]) begin
            rsp1_s.Rdata = rdata_s;
            rsp1_s.Ready = 1'b1;
          end else begin
            rsp0_s.Rdata = rdata_s;
            rsp0_s.Ready = 1'b1;
          end
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        grant_s = 2'b00;
        state_s = ST_IDLE;
      end
      default: begin
        grant_s = 2'b00;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      mem_r   <= '0;
      rsp0_r  <= '0;
      rsp1_r  <= '0;
      grant_r <= 2'b00;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      mem_r   <= mem_s;
      rsp0_r  <= rsp0_s;
      rsp1_r  <= rsp1_s;
      grant_r <= grant_s;
      last_r  <= last_s;
    end
  end

  assign mem_o   = mem_r;
  assign rsp0_o  = rsp0_r;
  assign rsp1_o  = rsp1_r;
  assign grant_o = grant_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected responses,
// a negedge monitor pops and checks port, data and arrival cycle.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  mem_input_t  req0, req1, mem_req;
  mem_output_t rsp0, rsp1, mem_rsp;
  logic [1:0]  grant;

  mem_input_t  fp_req0, fp_req1, fp_mem_req;
  mem_output_t fp_rsp0, fp_rsp1, fp_mem_rsp;
  logic [1:0]  fp_grant;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  mem_arbiter #(.RR_EN(1'b1), .FIXED_PRIO(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0), .rsp0_o(rsp0),
    .req1_i(req1), .rsp1_o(rsp1),
    .mem_o(mem_req), .mem_i(mem_rsp),
    .grant_o(grant)
  );

  mem_arbiter #(.RR_EN(1'b0), .FIXED_PRIO(1'b1)) dut_fp (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(fp_req0), .rsp0_o(fp_rsp0),
    .req1_i(fp_req1), .rsp1_o(fp_rsp1),
    .mem_o(fp_mem_req), .mem_i(fp_mem_rsp),
    .grant_o(fp_grant)
  );

  // Main memory model: 16 words, configurable response latency
  logic [31:0] mem_arr [16];
  bit          mem_loaded = 1'b0;
  int          mem_lat    = 1;
  int          pend_cnt   = 0;
  logic [31:0] pend_rd;
  logic [31:0] mem_rd;
  assign mem_rd = mem_req.Write ? 32'hBAD0_BAD0 : mem_arr[mem_req.Addr[5:2]];

  always @(posedge clk_i) begin
    mem_rsp.Ready <= 1'b0;
    if (!mem_loaded) begin
      mem_arr[0] <= 32'hDEAD_BEEF;
      mem_arr[1] <= 32'h0000_0000;
      mem_loaded <= 1'b1;
    end
    if (mem_req.Valid) begin
      if (mem_req.Write) mem_arr[mem_req.Addr[5:2]] <= mem_req.Wdata;
      if (mem_lat <= 1) begin
        mem_rsp.Ready <= 1'b1;
        mem_rsp.Rdata <= mem_rd;
      end else begin
        pend_cnt <= mem_lat - 1;
        pend_rd  <= mem_rd;
      end
    end else if (pend_cnt != 0) begin
      pend_cnt <= pend_cnt - 1;
      if (pend_cnt == 1) begin
        mem_rsp.Ready <= 1'b1;
        mem_rsp.Rdata <= pend_rd;
      end
    end
  end

  // Fixed-priority instance memory: answers every access one cycle later
  always @(posedge clk_i) begin
    fp_mem_rsp.Ready <= fp_mem_req.Valid & ~rst_i;
    fp_mem_rsp.Rdata <= 32'h0000_F00D;
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor for the round-robin instance
  always @(negedge clk_i) begin
    if (rsp0.Ready || rsp1.Ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", {70'd0, rsp1.Ready, rsp0.Ready}, 72'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_port", {70'd0, rsp1.Ready, rsp0.Ready}, e.port ? 72'd2 : 72'd1);
        check("rsp_data", {40'd0, (e.port ? rsp1.Rdata : rsp0.Rdata)}, {40'd0, e.data});
        check("rsp_cycle", 72'(cyc), 72'(e.cyc));
      end
    end
  end

  int fp_wins1 = 0;
  // Port 1 must win every arbitration in the fixed-priority instance
  always @(negedge clk_i) begin
    if (fp_rsp0.Ready) check("fp_port0_won", 72'd1, 72'd0);
    if (fp_rsp1.Ready) begin
      fp_wins1++;
      check("fp_rdata", {40'd0, fp_rsp1.Rdata}, 72'h0000_F00D);
    end
  end

  task automatic set_req(input bit port, input bit v, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wd);
    mem_input_t r;
    r.Valid = v; r.Write = wr; r.Addr = addr; r.Wdata = wd;
    if (port) req1 = r; else req0 = r;
  endtask

  task automatic drop(input bit port);
    if (port) req1.Valid = 1'b0; else req0.Valid = 1'b0;
  endtask

  // One transaction from a single requester; drop_at>0 drops Valid early
  task automatic txn(input bit port, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_data, input int drop_at);
    bit done = 1'b0;
    set_req(port, 1'b1, wr, addr, wd);
    sb_q.push_back('{port, exp_data, cyc + 3});
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk_i);
      if (k == drop_at) drop(port);
      if (port ? rsp1.Ready : rsp0.Ready) begin
        drop(port);
        done = 1'b1;
      end
    end
    if (!done) begin
      check("txn_timeout", 72'd0, 72'd1);
      drop(port);
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int seen;
    bit d0, d1;
    req0 = '0; req1 = '0; fp_req0 = '0; fp_req1 = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_mem_o", 72'(mem_req), 72'd0);
    check("rst_rsp0", 72'(rsp0), 72'd0);
    check("rst_rsp1", 72'(rsp1), 72'd0);
    check("rst_grant", 72'(grant), 72'd0);

    fp_req0 = '{Valid: 1'b1, Write: 1'b0, Addr: 32'h0001_0000, Wdata: 32'h0};
    fp_req1 = '{Valid: 1'b1, Write: 1'b0, Addr: 32'h0001_0004, Wdata: 32'h0};

    // T1: single port-0 read, mem_o.Valid exactly in the ISSUE cycle
    @(negedge clk_i);
    check("t1_idle_valid", 72'(mem_req.Valid), 72'd0);
    set_req(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0);
    sb_q.push_back('{1'b0, 32'hDEAD_BEEF, cyc + 3});
    @(negedge clk_i);
    check("t1_issue_valid", 72'(mem_req.Valid), 72'd1);
    check("t1_issue_addr", 72'(mem_req.Addr), 72'h0001_0000);
    check("t1_grant", 72'(grant), 72'd1);
    @(negedge clk_i);
    check("t1_wait_valid", 72'(mem_req.Valid), 72'd0);
    @(negedge clk_i);
    drop(1'b0);
    @(negedge clk_i);
    check("t1_grant_clear", 72'(grant), 72'd0);

    // T2: port-1 write then read back
    txn(1'b1, 1'b1, 32'h0001_0004, 32'h1234_5678, 32'h0, 0);
    txn(1'b1, 1'b0, 32'h0001_0004, 32'h0, 32'h1234_5678, 0);

    // T3: simultaneous reads after reset, port 0 first
    do_reset();
    p = cyc;
    set_req(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h0001_0004, 32'h0);
    sb_q.push_back('{1'b0, 32'hDEAD_BEEF, p + 3});
    sb_q.push_back('{1'b1, 32'h1234_5678, p + 7});
    d0 = 1'b0; d1 = 1'b0;
    for (int k = 1; k <= 30 && !(d0 && d1); k++) begin
      @(negedge clk_i);
      if (k == 1) check("t3_grant_first", 72'(grant), 72'd1);
      if (k == 5) check("t3_grant_second", 72'(grant), 72'd2);
      if (rsp0.Ready) begin drop(1'b0); d0 = 1'b1; end
      if (rsp1.Ready) begin drop(1'b1); d1 = 1'b1; end
    end
    check("t3_both_done", {70'd0, d1, d0}, 72'd3);
    @(negedge clk_i);

    // T4: both held for 16 transactions, strict alternation starting at port 0
    p = cyc;
    set_req(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h0001_0004, 32'h0);
    for (int k = 0; k < 16; k++)
      sb_q.push_back('{bit'(k % 2), ((k % 2) != 0) ? 32'h1234_5678 : 32'hDEAD_BEEF, p + 3 + 4 * k});
    seen = 0;
    for (int k = 1; k <= 100 && seen < 16; k++) begin
      @(negedge clk_i);
      if (rsp0.Ready || rsp1.Ready) seen++;
    end
    drop(1'b0); drop(1'b1);
    check("t4_count", 72'(seen), 72'd16);
    @(negedge clk_i);

    // T5: reset during WAIT while mainmem answers one cycle late
    mem_lat = 2;
    set_req(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0);
    sb_q.push_back('{1'b0, 32'hDEAD_BEEF, cyc + 3});
    repeat (2) @(negedge clk_i);
    check("t5_grant_wait", 72'(grant), 72'd1);
    rst_i = 1'b1;
    drop(1'b0);
    void'(sb_q.pop_back());
    @(negedge clk_i);
    rst_i = 1'b0;
    check("t5_mem_o", 72'(mem_req), 72'd0);
    check("t5_rsp0", 72'(rsp0), 72'd0);
    check("t5_rsp1", 72'(rsp1), 72'd0);
    check("t5_grant", 72'(grant), 72'd0);
    repeat (3) @(negedge clk_i);
    mem_lat = 1;
    txn(1'b0, 1'b0, 32'h0001_0000, 32'h0, 32'hDEAD_BEEF, 0);

    // T6: port 0 drops Valid during WAIT; transaction still completes
    txn(1'b0, 1'b0, 32'h0001_0000, 32'h0, 32'hDEAD_BEEF, 2);

    repeat (4) @(negedge clk_i);
    check("sb_empty", 72'(sb_q.size()), 72'd0);
    check("fp_port1_wins", 72'(fp_wins1 >= 16), 72'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
